// File: rtl/des_spi_pkg.sv
// Shared defaults and state encoding for the SPI mode-0 responder.
package des_spi_pkg;

   localparam int         DATA_WIDTH_DEF  = 8;
   localparam int         SYNC_STAGES_DEF = 2;
   localparam logic [7:0] IDLE_WORD_DEF   = 8'hFF;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_t;

endpackage

// File: rtl/des_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with rise/fall pulses
// derived from the synchronised level.
module des_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock_in,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/des_spi_slave.sv
// SPI mode-0 slave: oversampled SCLK/CS_N/MOSI, byte-wide rx/tx user interface.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | cs_n high; miso tristated, sclk edges ignored
//   ST_ACTIVE | cs_n low; shifting words, miso driven
module des_spi_slave
   import des_spi_pkg::*;
#(
   parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int                    SYNC_STAGES = SYNC_STAGES_DEF,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = IDLE_WORD_DEF
) (
   input  logic                  clock_in,
   input  logic                  reset_n,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  frame_err,
   output logic                  tx_underrun
);

   localparam int               CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   spi_state_t state_q, state_d;

   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic cs_rise, cs_fall, cs_lvl_unused;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   logic [CNT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-2:0] rx_shift;
   logic [DATA_WIDTH-1:0] rx_word;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  hold_full;
   logic                  word_done_q;

   logic slot_start, rx_en, word_done, tx_shift_en, frame_end;

   des_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .din      (sclk),
      .level    (sclk_lvl_unused),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   // cs_n resets high so leaving reset never fakes a frame start
   des_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .din      (cs_n),
      .level    (cs_lvl_unused),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   des_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .din      (mosi),
      .level    (mosi_s),
      .rise     (mosi_rise_unused),
      .fall     (mosi_fall_unused)
   );

   always_ff @(posedge clock_in) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
         ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // cs_n rise pre-empts any sclk edge seen in the same cycle
   always_comb begin
      slot_start  = 1'b0;
      rx_en       = 1'b0;
      word_done   = 1'b0;
      tx_shift_en = 1'b0;
      frame_end   = 1'b0;
      miso_oe     = 1'b0;
      unique case (state_q)
         ST_IDLE: slot_start = cs_fall;
         ST_ACTIVE: begin
            miso_oe = 1'b1;
            if (cs_rise) begin
               frame_end = 1'b1;
            end else begin
               rx_en       = sclk_rise;
               word_done   = sclk_rise && (bit_cnt == LAST_BIT);
               slot_start  = word_done;
               tx_shift_en = sclk_fall && (bit_cnt != '0);
            end
         end
         default: ;
      endcase
   end

   assign rx_word  = {rx_shift, mosi_s};
   assign miso     = miso_oe ? tx_shift[DATA_WIDTH-1] : 1'b1;
   assign tx_ready = ~hold_full;

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         bit_cnt     <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         word_done_q <= 1'b0;
         tx_shift    <= '0;
         hold_data   <= '0;
         hold_full   <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         word_done_q <= word_done;
         rx_valid    <= word_done_q;
         frame_err   <= frame_end && (bit_cnt != '0);
         tx_underrun <= slot_start && !hold_full;

         if (frame_end) begin
            bit_cnt <= '0;
         end else if (rx_en) begin
            rx_shift <= rx_word[DATA_WIDTH-2:0];
            bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
         end
         if (word_done) rx_data <= rx_word;

         if (slot_start)       tx_shift <= hold_full ? hold_data : IDLE_WORD;
         else if (tx_shift_en) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b1};

         // a same-cycle load after consume leaves the register full
         if (slot_start && hold_full) hold_full <= 1'b0;
         if (tx_valid && tx_ready) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_des_spi_slave.sv
// Directed bench for des_spi_slave: an SPI mode-0 master model drives the pins
// and compares received/returned words with hand-computed values.
`timescale 1ns/1ps
module tb_des_spi_slave;

   logic       clock_in = 1'b0;
   logic       reset_n  = 1'b0;
   logic       sclk     = 1'b0;
   logic       cs_n     = 1'b1;
   logic       mosi     = 1'b0;
   logic       miso, miso_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, frame_err, tx_underrun;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] rx_q[$];
   int         ferr_cnt = 0;
   int         undr_cnt = 0;

   des_spi_slave dut (
      .clock_in    (clock_in),
      .reset_n     (reset_n),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .frame_err   (frame_err),
      .tx_underrun (tx_underrun)
   );

   always #10 clock_in = ~clock_in;

   always @(negedge clock_in) begin
      if (rx_valid)    rx_q.push_back(rx_data);
      if (frame_err)   ferr_cnt++;
      if (tx_underrun) undr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic queue_tx(input logic [7:0] d);
      bit done = 0;
      @(negedge clock_in);
      tx_data  = d;
      tx_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         if (tx_ready) done = 1;
         @(posedge clock_in);
         #1;
      end
      tx_valid = 1'b0;
      check("tx_handshake", done, 1);
   endtask

   task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = mo[i];
         #500;
         sclk  = 1'b1;
         mi[i] = miso;
         #500;
         sclk  = 1'b0;
      end
   endtask

   task automatic frame_begin();
      @(negedge clock_in);
      cs_n = 1'b0;
      repeat (4) @(negedge clock_in);
   endtask

   task automatic frame_finish();
      #500;
      cs_n = 1'b1;
      repeat (10) @(negedge clock_in);
   endtask

   initial begin
      logic [7:0] mi, mi2;
      int rx0, fe0, un0;

      // 1: reset
      repeat (2) @(negedge clock_in);
      check("rst_miso_oe",  miso_oe,     0);
      check("rst_miso",     miso,        1);
      check("rst_tx_ready", tx_ready,    1);
      check("rst_rx_valid", rx_valid,    0);
      check("rst_rx_data",  rx_data,     0);
      check("rst_frame_err",frame_err,   0);
      check("rst_underrun", tx_underrun, 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clock_in);

      // 2: single word exchange, tx_ready latency
      rx0 = rx_q.size(); fe0 = ferr_cnt;
      queue_tx(8'hA5);
      @(negedge clock_in);
      check("t2_tx_full", tx_ready, 0);
      cs_n = 1'b0;
      @(posedge clock_in); @(posedge clock_in); #1;
      check("t2_txrdy_early", tx_ready, 0);
      @(posedge clock_in); #1;
      check("t2_txrdy_sync3", tx_ready, 1);
      check("t2_miso_oe", miso_oe, 1);
      @(negedge clock_in);
      spi_bits(8'h3C, 8, mi);
      frame_finish();
      check("t2_miso_word", mi, 8'hA5);
      check("t2_rx_count", rx_q.size() - rx0, 1);
      if (rx_q.size() > rx0) check("t2_rx_data", rx_q[rx0], 8'h3C);
      check("t2_oe_idle", miso_oe, 0);
      check("t2_no_ferr", ferr_cnt - fe0, 0);

      // 3: two words, only one queued
      rx0 = rx_q.size(); un0 = undr_cnt;
      queue_tx(8'h5A);
      frame_begin();
      spi_bits(8'h96, 8, mi);
      check("t3_undr_word2", undr_cnt - un0, 1);
      spi_bits(8'h69, 8, mi2);
      frame_finish();
      check("t3_miso_w1", mi,  8'h5A);
      check("t3_miso_w2", mi2, 8'hFF);
      check("t3_rx_count", rx_q.size() - rx0, 2);
      if (rx_q.size() > rx0 + 1) begin
         check("t3_rx_w1", rx_q[rx0],     8'h96);
         check("t3_rx_w2", rx_q[rx0 + 1], 8'h69);
      end

      // 4: partial word aborted, then a clean frame
      rx0 = rx_q.size(); fe0 = ferr_cnt;
      frame_begin();
      spi_bits(8'hC3, 5, mi);
      frame_finish();
      check("t4_rx_none", rx_q.size() - rx0, 0);
      check("t4_ferr_once", ferr_cnt - fe0, 1);
      frame_begin();
      spi_bits(8'h81, 8, mi);
      frame_finish();
      check("t4_ferr_total", ferr_cnt - fe0, 1);
      check("t4_rx_count", rx_q.size() - rx0, 1);
      check("t4_rx_data", rx_data, 8'h81);
      check("t4_idle_word", mi, 8'hFF);

      // 5: sclk toggling with cs_n high
      rx0 = rx_q.size(); fe0 = ferr_cnt;
      for (int i = 0; i < 4; i++) begin
         mosi = i[0];
         #500; sclk = 1'b1;
         #500; sclk = 1'b0;
         check("t5_oe_idle", miso_oe, 0);
      end
      repeat (10) @(negedge clock_in);
      check("t5_rx_none", rx_q.size() - rx0, 0);
      check("t5_rx_hold", rx_data, 8'h81);
      check("t5_no_ferr", ferr_cnt - fe0, 0);

      // 6: reset mid-word, then new frame
      rx0 = rx_q.size(); fe0 = ferr_cnt;
      frame_begin();
      spi_bits(8'hE5, 3, mi);
      @(negedge clock_in);
      reset_n = 1'b0;
      cs_n    = 1'b1;
      repeat (2) @(negedge clock_in);
      check("t6_rst_oe", miso_oe, 0);
      check("t6_rst_rx", rx_data, 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clock_in);
      frame_begin();
      spi_bits(8'h7E, 8, mi);
      frame_finish();
      check("t6_rx_count", rx_q.size() - rx0, 1);
      check("t6_rx_data", rx_data, 8'h7E);
      check("t6_no_ferr", ferr_cnt - fe0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
